// File: rtl/data_mem_responder_pkg.sv
// Shared types and default sizes for the multi-channel data memory responder.
package data_mem_responder_pkg;

   localparam int DEF_ADDR_BITS = 8;
   localparam int DEF_DATA_BITS = 8;
   localparam int DEF_CHANNELS  = 4;
   localparam int DEF_LATENCY   = 2;

   typedef enum logic [1:0] {
      CH_IDLE,
      CH_WAIT,
      CH_READ_DONE,
      CH_WRITE_DONE
   } ch_state_e;

   function automatic int ptr_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/data_mem_responder_arb.sv
// Round-robin arbiter for the single array port; the search starts at rr and
// rr moves one past the winner after every grant.
module mem_rr_arbiter
   import data_mem_responder_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                block,
   input  logic [CHANNELS-1:0] req,
   output logic [CHANNELS-1:0] grant
);

   localparam int PW = ptr_bits(CHANNELS);

   logic [PW-1:0] rr_q, rr_d;
   logic          found;
   int            idx;

   always_comb begin
      grant = '0;
      rr_d  = rr_q;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < CHANNELS; i++) begin
         idx = (int'(rr_q) + i) % CHANNELS;
         if (!block && !found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            rr_d       = PW'((idx + 1) % CHANNELS);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) rr_q <= '0;
      else       rr_q <= rr_d;
   end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-channel request/response front end for a single-ported word array,
// with a host backdoor load port that pre-empts all channel traffic.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int ADDR_BITS = DEF_ADDR_BITS,
   parameter int DATA_BITS = DEF_DATA_BITS,
   parameter int CHANNELS  = DEF_CHANNELS,
   parameter int LATENCY   = DEF_LATENCY
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [CHANNELS-1:0]                  read_valid,
   input  logic [CHANNELS-1:0][ADDR_BITS-1:0]   read_address,
   output logic [CHANNELS-1:0]                  read_ready,
   output logic [CHANNELS-1:0][DATA_BITS-1:0]   read_data,
   input  logic [CHANNELS-1:0]                  write_valid,
   input  logic [CHANNELS-1:0][ADDR_BITS-1:0]   write_address,
   input  logic [CHANNELS-1:0][DATA_BITS-1:0]   write_data,
   output logic [CHANNELS-1:0]                  write_ready,
   input  logic                                 load_enable,
   input  logic [ADDR_BITS-1:0]                 load_address,
   input  logic [DATA_BITS-1:0]                 load_data
);

   localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

   ch_state_e                            state_q [CHANNELS];
   ch_state_e                            state_d [CHANNELS];
   logic [CHANNELS-1:0][CW-1:0]          count_q, count_d;
   logic [CHANNELS-1:0][ADDR_BITS-1:0]   addr_q, addr_d;
   logic [CHANNELS-1:0][DATA_BITS-1:0]   wdata_q, wdata_d;
   logic [CHANNELS-1:0][DATA_BITS-1:0]   rdata_q, rdata_d;
   logic [CHANNELS-1:0]                  is_write_q, is_write_d;
   logic [CHANNELS-1:0]                  arb_req, arb_grant;

   logic [DATA_BITS-1:0]                 mem_q [2**ADDR_BITS];
   logic                                 mem_we;
   logic [ADDR_BITS-1:0]                 mem_waddr;
   logic [DATA_BITS-1:0]                 mem_wdata, mem_rdata;
   logic                                 g_write;
   logic [ADDR_BITS-1:0]                 g_addr;
   logic [DATA_BITS-1:0]                 g_wdata;

   // Reset also blocks grants so a pending write never lands on the reset edge.
   mem_rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
      .clk   (clk),
      .reset (reset),
      .block (load_enable | reset),
      .req   (arb_req),
      .grant (arb_grant)
   );

   always_comb begin
      for (int c = 0; c < CHANNELS; c++)
         arb_req[c] = (state_q[c] == CH_WAIT) && (count_q[c] == '0);
   end

   always_comb begin
      g_addr  = '0;
      g_wdata = '0;
      g_write = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (arb_grant[c]) begin
            g_addr  = addr_q[c];
            g_wdata = wdata_q[c];
            g_write = is_write_q[c];
         end
      end
   end

   assign mem_rdata = mem_q[g_addr];

   always_comb begin
      mem_we    = load_enable | (|arb_grant & g_write);
      mem_waddr = load_enable ? load_address : g_addr;
      mem_wdata = load_enable ? load_data    : g_wdata;
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         state_d[c]    = state_q[c];
         count_d[c]    = count_q[c];
         addr_d[c]     = addr_q[c];
         wdata_d[c]    = wdata_q[c];
         rdata_d[c]    = rdata_q[c];
         is_write_d[c] = is_write_q[c];
         case (state_q[c])
            CH_IDLE: begin
               if (read_valid[c]) begin
                  addr_d[c]     = read_address[c];
                  is_write_d[c] = 1'b0;
                  count_d[c]    = CW'(LATENCY);
                  state_d[c]    = CH_WAIT;
               end else if (write_valid[c]) begin
                  addr_d[c]     = write_address[c];
                  wdata_d[c]    = write_data[c];
                  is_write_d[c] = 1'b1;
                  count_d[c]    = CW'(LATENCY);
                  state_d[c]    = CH_WAIT;
               end
            end
            CH_WAIT: begin
               if (count_q[c] != '0) begin
                  count_d[c] = count_q[c] - CW'(1);
               end else if (arb_grant[c]) begin
                  if (is_write_q[c]) begin
                     state_d[c] = CH_WRITE_DONE;
                  end else begin
                     state_d[c] = CH_READ_DONE;
                     rdata_d[c] = mem_rdata;
                  end
               end
            end
            CH_READ_DONE: begin
               if (!read_valid[c]) begin
                  state_d[c] = CH_IDLE;
                  rdata_d[c] = '0;
               end
            end
            CH_WRITE_DONE: begin
               if (!write_valid[c]) state_d[c] = CH_IDLE;
            end
            default: state_d[c] = CH_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < CHANNELS; c++) begin
         if (reset) begin
            state_q[c]    <= CH_IDLE;
            count_q[c]    <= '0;
            addr_q[c]     <= '0;
            wdata_q[c]    <= '0;
            rdata_q[c]    <= '0;
            is_write_q[c] <= 1'b0;
         end else begin
            state_q[c]    <= state_d[c];
            count_q[c]    <= count_d[c];
            addr_q[c]     <= addr_d[c];
            wdata_q[c]    <= wdata_d[c];
            rdata_q[c]    <= rdata_d[c];
            is_write_q[c] <= is_write_d[c];
         end
      end
   end

   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         read_ready[c]  = (state_q[c] == CH_READ_DONE);
         write_ready[c] = (state_q[c] == CH_WRITE_DONE);
         read_data[c]   = read_ready[c] ? rdata_q[c] : '0;
      end
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADDR_BITS, 8, word-address width.
REQ-002 Parameter DATA_BITS, 8, word width.
REQ-003 Parameter CHANNELS, 4, number of independent request channels.
REQ-004 Parameter LATENCY, 2, extra wait cycles before arbitration (0 legal).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 read_valid  input  [CHANNELS]  per-channel read request, held high by the requester until read_ready is seen.
REQ-008 read_address  input  [CHANNELS][ADDR_BITS]  read address, stable while read_valid is high.
REQ-009 read_ready  output  [CHANNELS]  read data valid and request complete.
REQ-010 read_data  output  [CHANNELS][DATA_BITS]  returned word.
REQ-011 write_valid  input  [CHANNELS]  per-channel write request, held until write_ready.
REQ-012 write_address  input  [CHANNELS][ADDR_BITS]  write address.
REQ-013 write_data  input  [CHANNELS][DATA_BITS]  write word.
REQ-014 write_ready  output  [CHANNELS]  write committed.
REQ-015 load_enable  input  1  host backdoor write strobe.
REQ-016 load_address  input  ADDR_BITS  backdoor address.
REQ-017 load_data  input  DATA_BITS  backdoor word.

Function
REQ-018 Storage SHALL be 2^ADDR_BITS words of DATA_BITS, single-ported: at most one array access per cycle.
REQ-019 Each channel SHALL run its own FSM: IDLE, WAIT, READ_DONE, WRITE_DONE.
REQ-020 IDLE: on an edge sampling read_valid=1, latch the address and op=read, load count=LATENCY, go to WAIT; else if write_valid=1, latch address, data and op=write, same transition; read wins when both are high.
REQ-021 WAIT: count!=0 -> decrement; count==0 -> raise the array request; when granted, perform the access and go to READ_DONE or WRITE_DONE.
REQ-022 Uncontested timing: accept at edge E0, access at edge E0+1+LATENCY, ready high from that edge.
REQ-023 Grant SHALL be round-robin among requesting channels starting at pointer rr; after a grant, rr = granted+1 mod CHANNELS.
REQ-024 A high load_enable SHALL write the array that cycle, take priority over all channels and block any grant that cycle; requesters stay in WAIT.
REQ-025 READ_DONE: read_ready=1 and read_data holds the word captured at access; the word SHALL NOT change if the address is later overwritten.
REQ-026 WRITE_DONE: write_ready=1; the array already holds the new word.
REQ-027 DONE states: on an edge sampling the matching valid low, go to IDLE; ready drops after that edge; a new request can be accepted no earlier than the following edge.
REQ-028 A valid dropped during WAIT SHALL NOT abort: the access completes, ready pulses one cycle, then IDLE.
REQ-029 Read and write to the same address from different channels SHALL be ordered by grant order; a read granted after the write returns the new word.
REQ-030 read_data SHALL be 0 in every state except READ_DONE.

Reset
REQ-031 On reset all FSMs SHALL go to IDLE, all ready outputs and read_data to 0, and rr and counters to 0.
REQ-032 Reset SHALL NOT clear array contents; a pending write not yet granted when reset is sampled SHALL NOT be performed.

Structure
REQ-033 A shared package SHALL hold the channel-state enum and the default width constants (8/8/4).
REQ-034 The round-robin grant logic SHALL be a sub-module, mem_rr_arbiter (CHANNELS-bit request in, one-hot grant out, internal pointer).

Verification
REQ-035 LATENCY=2: load mem[5]=0x2A, ch0 read addr 5 accepted at E0 -> read_ready rises at E3, read_data=0x2A; valid dropped at E4 -> ready low after E4.
REQ-036 All 4 channels read addr 0..3 in the same cycle, rr=0 -> ready at consecutive edges in order ch0, ch1, ch2, ch3; rr ends at 0.
REQ-037 ch1 writes 0x11 to addr 9, then ch2 reads addr 9 -> read_data=0x11; a later write of 0x22 leaves ch2's held read_data at 0x11.
REQ-038 load_enable held 3 cycles while ch0 is pending at count 0 -> no grant during those cycles, grant on the first cycle after.
REQ-039 Reset sampled while ch3 write to addr 7 (old 0x05) is in WAIT -> mem[7] stays 0x05, all ready outputs 0, FSMs IDLE.
REQ-040 Matrix add, 8 threads: preload A=B=0..7 at addr 0..15 -> addr 16..23 hold 0,2,4,...,14.
